// File: rtl/shift_pkg.sv
// Shared state encoding for the serial right shifter.
package shift_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/right_shift_by_one.sv
// Combinational single-bit right shift stage; MSB fill is the sign bit when arith=1, else zero.
module right_shift_by_one #(
  parameter int N = 8
) (
  input  logic [N-1:0] a,
  input  logic         arith,
  output logic [N-1:0] res
);

  assign res = {arith & a[N-1], a[N-1:1]};

endmodule

// File: rtl/serial_right_shifter.sv
// Multi-cycle right shifter: one bit per clock through a single one-bit stage, valid/ready on both sides.
//
// state    | meaning
// ST_IDLE  | waiting for an operand, in_ready=1
// ST_SHIFT | shifting one bit per clock, r_cnt bits remaining
// ST_DONE  | result held on out_data until out_ready
module serial_right_shifter
  import shift_pkg::*;
#(
  parameter int N  = 8,
  parameter int SW = $clog2(N)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [N-1:0]  in_data,
  input  logic [SW-1:0] in_shamt,
  input  logic          in_arith,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [N-1:0]  out_data,
  output logic          busy
);

  state_t        r_state;
  logic [N-1:0]  r_data;
  logic [SW-1:0] r_cnt;
  logic          r_arith;
  logic [N-1:0]  w_shifted;

  right_shift_by_one #(.N(N)) u_shift1 (
    .a     (r_data),
    .arith (r_arith),
    .res   (w_shifted)
  );

  // The sign bit never changes under an arithmetic shift, so the stage can read it from r_data[N-1].
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_data  <= '0;
      r_cnt   <= '0;
      r_arith <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (in_valid) begin
            r_data  <= in_data;
            r_cnt   <= in_shamt;
            r_arith <= in_arith;
            r_state <= (in_shamt != '0) ? ST_SHIFT : ST_DONE;
          end
        end
        ST_SHIFT: begin
          r_data <= w_shifted;
          r_cnt  <= r_cnt - 1'b1;
          if (r_cnt == SW'(1)) begin
            r_state <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign in_ready  = (r_state == ST_IDLE);
  assign out_valid = (r_state == ST_DONE);
  assign busy      = (r_state != ST_IDLE);
  assign out_data  = r_data;

endmodule

// File: tb/tb_serial_right_shifter.sv
// Self-checking bench for serial_right_shifter: directed corner cases, then a randomized regression.
module tb_serial_right_shifter;

  localparam int N  = 8;
  localparam int SW = 3;

  logic          clk;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [N-1:0]  in_data;
  logic [SW-1:0] in_shamt;
  logic          in_arith;
  logic          out_valid;
  logic          out_ready;
  logic [N-1:0]  out_data;
  logic          busy;

  serial_right_shifter #(.N(N), .SW(SW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_shamt  (in_shamt),
    .in_arith  (in_arith),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [N-1:0] ref_shift(input logic [N-1:0] d, input int s, input logic a);
    logic signed [N-1:0] sd;
    sd = d;
    if (a) return N'(sd >>> s);
    return d >> s;
  endfunction

  typedef struct {
    logic [N-1:0] exp;
    int           shamt;
    int           acc_cyc;
  } txn_t;

  txn_t q[$];
  bit   run_mon = 0;
  int   cyc = 0;
  int   n_acc = 0;
  int   n_out = 0;
  bit   prev_ov = 0;

  // Scoreboard for the random phase; everything is sampled on the falling edge.
  always @(negedge clk) begin
    if (run_mon) begin
      cyc++;
      if (in_valid && in_ready) begin
        q.push_back('{ref_shift(in_data, int'(in_shamt), in_arith), int'(in_shamt), cyc});
        n_acc++;
      end
      if (out_valid) begin
        check("rnd_overlap", {31'd0, in_ready}, 32'd0);
        if (q.size() == 0) begin
          check("rnd_spurious_out", 32'd1, 32'd0);
        end else begin
          check("rnd_data", {24'd0, out_data}, {24'd0, q[0].exp});
          if (!prev_ov) check("rnd_latency", cyc - q[0].acc_cyc - 1, q[0].shamt);
          if (out_ready) begin
            void'(q.pop_front());
            n_out++;
          end
        end
      end
      prev_ov = out_valid && !out_ready;
    end
  end

  // Drives one operand from IDLE with out_ready=1 and checks latency, result and return to IDLE.
  task automatic do_op(input string tag, input logic [N-1:0] d, input int s, input logic a,
                       input logic [N-1:0] exp);
    int lat;
    in_valid = 1'b1; in_data = d; in_shamt = SW'(s); in_arith = a; out_ready = 1'b1;
    @(negedge clk);
    check({tag, "_in_ready"}, {31'd0, in_ready}, 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0; in_data = 8'($urandom); in_shamt = SW'($urandom); in_arith = 1'($urandom);
    lat = 0;
    @(negedge clk);
    while (!out_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check({tag, "_latency"}, lat, s);
    check({tag, "_out_valid"}, {31'd0, out_valid}, 32'd1);
    check({tag, "_data"}, {24'd0, out_data}, {24'd0, exp});
    check({tag, "_no_in_ready"}, {31'd0, in_ready}, 32'd0);
    @(posedge clk); #1;
    check({tag, "_back_idle"}, {30'd0, in_ready, out_valid}, 32'd2);
  endtask

  initial begin
    int lat;
    int n_ov;
    int guard;

    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_shamt = '0; in_arith = 1'b0; out_ready = 1'b0;
    #1;
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_out_data", {24'd0, out_data}, 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    do_op("logic_b4_3", 8'hB4, 3, 1'b0, 8'h16);
    do_op("arith_b4_3", 8'hB4, 3, 1'b1, 8'hF6);
    do_op("arith_81_0", 8'h81, 0, 1'b1, 8'h81);
    do_op("arith_80_7", 8'h80, 7, 1'b1, 8'hFF);
    do_op("logic_7f_1", 8'h7F, 1, 1'b0, 8'h3F);

    // Backpressure: hold out_ready low while a second operand is offered continuously.
    in_valid = 1'b1; in_data = 8'h80; in_shamt = 3'd7; in_arith = 1'b0; out_ready = 1'b0;
    @(posedge clk); #1;
    in_data = 8'h55; in_shamt = 3'd0; in_arith = 1'b1;
    lat = 0;
    @(negedge clk);
    while (!out_valid && lat < 20) begin
      check("bp_ignore_in_ready", {31'd0, in_ready}, 32'd0);
      @(negedge clk);
      lat++;
    end
    check("bp_latency", lat, 7);
    for (int i = 0; i < 5; i++) begin
      check("bp_hold_data", {24'd0, out_data}, 32'h01);
      check("bp_hold_state", {30'd0, in_ready, out_valid}, 32'd1);
      @(negedge clk);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_idle_after_consume", {30'd0, in_ready, out_valid}, 32'd2);
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    check("bp_second_valid", {31'd0, out_valid}, 32'd1);
    check("bp_second_data", {24'd0, out_data}, 32'h55);
    @(posedge clk); #1;

    // Reset in the middle of a shift.
    in_valid = 1'b1; in_data = 8'hFF; in_shamt = 3'd5; in_arith = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    check("mid_rst_busy_before", {31'd0, busy}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_outputs", {29'd0, in_ready, out_valid, busy}, 32'd4);
    check("mid_rst_data", {24'd0, out_data}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    n_ov = 0;
    repeat (12) begin
      @(negedge clk);
      if (out_valid) n_ov++;
    end
    check("mid_rst_no_out", n_ov, 0);
    @(posedge clk); #1;

    // Randomized regression.
    run_mon = 1;
    guard = 0;
    while (n_acc < 1000 && guard < 60000) begin
      @(posedge clk); #1;
      in_valid  = ($urandom % 10) < 7;
      in_data   = 8'($urandom);
      in_shamt  = SW'($urandom);
      in_arith  = 1'($urandom);
      out_ready = ($urandom % 10) < 6;
      guard++;
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    guard = 0;
    while (q.size() != 0 && guard < 100) begin
      @(posedge clk); #1;
      guard++;
    end
    check("rnd_drain_timeout", {31'd0, guard >= 100}, 32'd0);
    check("rnd_accepted", n_acc, 1000);
    check("rnd_delivered", n_out, 1000);
    run_mon = 0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/serial_right_shifter.md
SERIAL_RIGHT_SHIFTER -- requirements
Module: serial_right_shifter

Interface
REQ-001 The block SHALL have parameter N, default 8, meaning operand width in bits (N >= 2).
REQ-002 The block SHALL have parameter SW, default $clog2(N), meaning shift-amount width.
REQ-003 The block SHALL have port clk, input, 1, meaning the single clock; all state is updated on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1, meaning the reset: asynchronous and active-low.
REQ-005 The block SHALL have port in_valid, input, 1, meaning upstream offers an operand.
REQ-006 The block SHALL have port in_ready, output, 1, meaning the block can accept an operand.
REQ-007 The block SHALL have port in_data, input, N, meaning the unsigned (or two's-complement, if in_arith) operand.
REQ-008 The block SHALL have port in_shamt, input, SW, meaning the right-shift amount, 0..N-1.
REQ-009 The block SHALL have port in_arith, input, 1, meaning 1 = arithmetic shift (sign fill) and 0 = logical shift (zero fill).
REQ-010 The block SHALL have port out_valid, output, 1, meaning the result is available.
REQ-011 The block SHALL have port out_ready, input, 1, meaning downstream accepts the result.
REQ-012 The block SHALL have port out_data, output, N, meaning the shifted result.
REQ-013 The block SHALL have port busy, output, 1, meaning the FSM is not in IDLE.

Function
REQ-014 The FSM SHALL have exactly three states, IDLE, SHIFT and DONE, with in_ready = (state==IDLE), out_valid = (state==DONE) and busy = (state!=IDLE), all decoded from registered state only.
REQ-015 In IDLE, in_valid=1 at a rising edge (the accept edge) SHALL capture in_data, in_shamt and in_arith into internal registers and transition to SHIFT if in_shamt!=0, else to DONE.
REQ-016 In SHIFT, each clock edge SHALL shift the data register right by exactly one bit, filling the MSB with the captured sign bit if arith=1, else 0, and decrement the remaining-count register.
REQ-017 SHIFT SHALL transition to DONE on the edge that performs the final (shamt-th) one-bit shift.
REQ-018 The first out_valid=1 cycle SHALL begin immediately after rising edge E0+in_shamt, where E0 is the accept edge (latency = in_shamt cycles after accept; shamt=0 gives 0 extra cycles).
REQ-019 In DONE, out_data SHALL equal the shift result and SHALL hold stable while out_valid=1 and out_ready=0.
REQ-020 In DONE, out_ready=1 at a rising edge SHALL transition to IDLE; in_ready SHALL NOT rise in the same cycle as out_valid, so there is no overlap and peak throughput is one operand per shamt+2 cycles.
REQ-021 in_valid, in_data, in_shamt and in_arith SHALL be ignored while state!=IDLE.
REQ-022 The result SHALL equal in_data >> in_shamt when logical, and $signed(in_data) >>> in_shamt when arithmetic, bit-exact for every shamt in 0..N-1.
REQ-023 out_data SHALL be driven from the data register in all states; its value outside DONE is don't-care for downstream, but it SHALL remain deterministic.
REQ-024 An in_valid that is held continuously SHALL be accepted again on the first IDLE cycle after a result is consumed.

Reset
REQ-025 rst_n=0 SHALL immediately (asynchronously) force state=IDLE, out_valid=0, in_ready=1 after reset, busy=0, out_data=0, and count=0.
REQ-026 Reset asserted mid-SHIFT or in DONE SHALL discard the operation; after rst_n deasserts, no out_valid SHALL appear without a new accept.
REQ-027 Reset deassertion SHALL be synchronised externally; the block SHALL NOT add a reset synchroniser.

Structure
REQ-028 Package shift_pkg SHALL hold the state enum typedef (ST_IDLE, ST_SHIFT, ST_DONE) and no other declarations.
REQ-029 Sub-module right_shift_by_one (parameter N; inputs a, arith; output res) SHALL be the combinational one-bit stage, instantiated once.
REQ-030 The design SHALL contain no multi-bit shift operator on data; all shifting goes through right_shift_by_one.

Verification
REQ-031 N=8, accept in_data=8'hB4, shamt=3, arith=0, out_ready=1 -> out_valid in the cycle after E0+3, out_data=8'h16, then IDLE.
REQ-032 N=8, in_data=8'hB4, shamt=3, arith=1 -> out_data=8'hF6.
REQ-033 shamt=0, in_data=8'h81, arith=1 -> out_valid in the cycle after E0, out_data=8'h81.
REQ-034 shamt=7, in_data=8'h80, arith=0 -> 8'h01; with out_ready held 0 for 5 cycles -> out_data stable, in_ready=0 throughout, and a second in_valid is ignored.
REQ-035 rst_n pulsed low during SHIFT (shamt=5, after 2 shifts) -> outputs reset immediately; no out_valid after release until a new accept.
REQ-036 Random regression: 1000 operands, random shamt, arith, in_valid and out_ready gaps -> every result matches the REQ-022 model, with in-order, one-for-one transfers.
